// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and constants for the PWM ramp controller slice (package pwm_pkg).
package pwm_pkg;

  localparam int unsigned DEF_BITS     = 16;
  localparam int unsigned DEF_IVL_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STEP
  } state_t;

  // Last counter value of a PWM period; the period is period_max(bits)+1 clocks.
  function automatic int unsigned period_max(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command port of the PWM ramp controller: valid/ready handshake carrying
// target duty, step magnitude and inter-step interval.
interface pwm_ramp_ctrl_if
  import pwm_pkg::*;
#(
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned IVL_BITS = DEF_IVL_BITS
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [BITS-1:0]     cmd_target;
  logic [BITS-1:0]     cmd_step;
  logic [IVL_BITS-1:0] cmd_interval;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    output cmd_interval,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    input  cmd_interval,
    output cmd_ready
  );

endinterface

// File: rtl/pwm_ramp_ctrl_step.sv
// Combinational ramp step: moves duty toward target by step (0 acts as 1),
// clamping onto target when the remaining distance is within one step.
module pwm_ramp_step
  import pwm_pkg::*;
#(
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic [BITS-1:0] duty,
  input  logic [BITS-1:0] target,
  input  logic [BITS-1:0] step,
  output logic [BITS-1:0] next_duty,
  output logic            finished
);

  logic [BITS-1:0] step_eff;
  logic [BITS:0]   diff;
  logic            up;

  // Distance computed one bit wider so the clamp decision never wraps.
  always_comb begin
    step_eff  = (step == '0) ? BITS'(1) : step;
    up        = (target >= duty);
    diff      = up ? ({1'b0, target} - {1'b0, duty}) : ({1'b0, duty} - {1'b0, target});
    finished  = (diff <= {1'b0, step_eff});
    next_duty = target;
    if (!finished) begin
      next_duty = up ? (duty + step_eff) : (duty - step_eff);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM ramp controller: owns the PWM period counter and compare output and ramps
// the live duty toward a commanded target, updating duty only right after a
// period wrap so every period sees a single duty value.
// Optional feature macro: PWM_RAMP_DONE_EN adds a one-cycle `done` pulse.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned BITS     = DEF_BITS,
  parameter int unsigned IVL_BITS = DEF_IVL_BITS
) (
  input  logic              clk,
  input  logic              reset,
  pwm_ramp_ctrl_if.slave    cmd,
  input  logic              abort,
  output logic [BITS-1:0]   duty,
  output logic              busy,
  output logic              out
`ifdef PWM_RAMP_DONE_EN
  ,
  output logic              done
`endif
);

  localparam logic [BITS:0] CNT_MAX = (BITS+1)'(period_max(BITS));

  logic [BITS:0]       cnt;
  logic                wrap;
  state_t              state;
  logic [BITS-1:0]     tgt;
  logic [BITS-1:0]     stp;
  logic [IVL_BITS-1:0] ivl;
  logic [IVL_BITS-1:0] ivl_cnt;
  logic [BITS-1:0]     step_next;
  logic                step_fin;

  assign wrap = (cnt == CNT_MAX);

  // Period counter: 0..2^BITS then back to 0.
  always_ff @(posedge clk) begin
    if (reset || wrap) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  // Registered compare output.
  always_ff @(posedge clk) begin
    if (reset) out <= 1'b0;
    else       out <= ({1'b0, duty} >= cnt);
  end

  pwm_ramp_step #(.BITS(BITS)) u_step (
    .duty      (duty),
    .target    (tgt),
    .step      (stp),
    .next_duty (step_next),
    .finished  (step_fin)
  );

  // Ramp sequencer with registered busy/ready; abort takes priority over wrap.
  always_ff @(posedge clk) begin
`ifdef PWM_RAMP_DONE_EN
    done <= 1'b0;
`endif
    if (reset) begin
      state         <= IDLE;
      duty          <= '0;
      busy          <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      tgt           <= '0;
      stp           <= '0;
      ivl           <= '0;
      ivl_cnt       <= '0;
`ifdef PWM_RAMP_DONE_EN
      done          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            tgt           <= cmd.cmd_target;
            stp           <= cmd.cmd_step;
            ivl           <= cmd.cmd_interval;
            ivl_cnt       <= cmd.cmd_interval;
            state         <= WAIT;
            busy          <= 1'b1;
            cmd.cmd_ready <= 1'b0;
          end
        end
        WAIT: begin
          if (abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
          end else if (wrap) begin
            if (ivl_cnt == '0) state <= STEP;
            else               ivl_cnt <= ivl_cnt - 1'b1;
          end
        end
        STEP: begin
          if (abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
          end else begin
            duty <= step_next;
            if (step_fin) begin
              state         <= IDLE;
              busy          <= 1'b0;
              cmd.cmd_ready <= 1'b1;
`ifdef PWM_RAMP_DONE_EN
              done          <= 1'b1;
`endif
            end else begin
              ivl_cnt <= ivl;
              state   <= WAIT;
            end
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl (BITS=4, period 17 cycles).
// Honours PWM_RAMP_DONE_EN when the design is built with it.
module tb_pwm_ramp_ctrl;
  import pwm_pkg::*;

  localparam int unsigned BITS     = 4;
  localparam int unsigned IVL_BITS = 4;
  localparam int          PERIOD   = 17;

  logic            clk = 1'b0;
  logic            reset;
  logic            abort;
  logic [BITS-1:0] duty;
  logic            busy;
  logic            out;
  int              checks = 0;
  int              errors = 0;
  int              n;
  int              hi;
  int              w;
`ifdef PWM_RAMP_DONE_EN
  logic            done;
  int              done_cnt = 0;
  int              done_ref;
`endif

  pwm_ramp_ctrl_if #(.BITS(BITS), .IVL_BITS(IVL_BITS)) cmd_if ();

  pwm_ramp_ctrl #(.BITS(BITS), .IVL_BITS(IVL_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if.slave),
    .abort (abort),
    .duty  (duty),
    .busy  (busy),
    .out   (out)
`ifdef PWM_RAMP_DONE_EN
    ,
    .done  (done)
`endif
  );

  always #5 clk = ~clk;

`ifdef PWM_RAMP_DONE_EN
  always @(negedge clk) if (done === 1'b1) done_cnt++;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the command until the DUT is ready, then completes the handshake.
  task automatic send(input logic [BITS-1:0] t, input logic [BITS-1:0] s,
                      input logic [IVL_BITS-1:0] iv, output int waited);
    cmd_if.cmd_valid    = 1'b1;
    cmd_if.cmd_target   = t;
    cmd_if.cmd_step     = s;
    cmd_if.cmd_interval = iv;
    waited = 0;
    while (cmd_if.cmd_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) check("send_timeout", 32'd0, 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_ready_low", 32'(cmd_if.cmd_ready), 32'd0);
  endtask

  task automatic wait_change(input string tag, input int exp, input int budget, output int cnt);
    logic [BITS-1:0] start;
    start = duty;
    cnt = 0;
    while (duty === start && cnt < budget) begin
      tick();
      cnt++;
    end
    check(tag, 32'(duty), 32'(exp));
  endtask

  task automatic count_high(input int cycles, output int h);
    h = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out === 1'b1) h++;
    end
  endtask

  initial begin
    cmd_if.cmd_valid    = 1'b0;
    cmd_if.cmd_target   = '0;
    cmd_if.cmd_step     = '0;
    cmd_if.cmd_interval = '0;
    abort = 1'b0;
    reset = 1'b1;

    // 1. reset and idle output
    tick();
    tick();
    check("rst_out", 32'(out), 32'd0);
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    reset = 1'b0;
    count_high(2 * PERIOD, hi);
    check("idle_high", 32'(hi), 32'd2);

    // 2. ramp 0 -> 8 step 2 every period
`ifdef PWM_RAMP_DONE_EN
    done_ref = done_cnt;
`endif
    send(4'd8, 4'd2, 4'd0, w);
    wait_change("t2_d2", 2, 40, n);
    check("t2_first_lat", 32'(n >= 2 && n <= 18), 32'd1);
    wait_change("t2_d4", 4, 40, n);
    check("t2_per4", 32'(n), 32'(PERIOD));
    wait_change("t2_d6", 6, 40, n);
    check("t2_per6", 32'(n), 32'(PERIOD));
    wait_change("t2_d8", 8, 40, n);
    check("t2_per8", 32'(n), 32'(PERIOD));
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_ready", 32'(cmd_if.cmd_ready), 32'd1);
    count_high(PERIOD, hi);
    check("t2_high", 32'(hi), 32'd9);
`ifdef PWM_RAMP_DONE_EN
    check("t2_done", 32'(done_cnt - done_ref), 32'd1);
`endif

    // 3. ramp down 8 -> 3 step 4, clamped on the last step
    send(4'd3, 4'd4, 4'd0, w);
    wait_change("t3_d4", 4, 40, n);
    wait_change("t3_d3", 3, 40, n);
    check("t3_per", 32'(n), 32'(PERIOD));
    check("t3_busy", 32'(busy), 32'd0);
    count_high(PERIOD, hi);
    check("t3_high", 32'(hi), 32'd4);

    // 4. single step 0 -> 15 after three wraps
    send(4'd0, 4'd15, 4'd0, w);
    wait_change("t4_d0", 0, 40, n);
    send(4'd15, 4'd15, 4'd2, w);
    wait_change("t4_d15", 15, 100, n);
    check("t4_lat", 32'(n >= 36 && n <= 52), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    count_high(PERIOD, hi);
    check("t4_high", 32'(hi), 32'd16);

    // 5. abort at duty 6 during 0 -> 12 step 3
    send(4'd0, 4'd15, 4'd0, w);
    wait_change("t5_d0", 0, 40, n);
    send(4'd12, 4'd3, 4'd0, w);
    wait_change("t5_d3", 3, 40, n);
    wait_change("t5_d6", 6, 40, n);
`ifdef PWM_RAMP_DONE_EN
    done_ref = done_cnt;
`endif
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
    count_high(3 * PERIOD, hi);
    check("t5_hold_duty", 32'(duty), 32'd6);
    check("t5_hold_high", 32'(hi), 32'd21);
`ifdef PWM_RAMP_DONE_EN
    check("t5_no_done", 32'(done_cnt - done_ref), 32'd0);
`endif
    // command presented while busy waits for the ramp 6 -> 10 to finish
    send(4'd10, 4'd1, 4'd0, w);
    send(4'd9, 4'd15, 4'd0, w);
    check("t5_pending_wait", 32'(w >= 53 && w <= 69), 32'd1);
    check("t5_pending_duty", 32'(duty), 32'd10);
    wait_change("t5_d9", 9, 40, n);

    // 6. reset mid-ramp, then step=0 behaves as step=1
    send(4'd15, 4'd1, 4'd0, w);
    wait_change("t6_d10", 10, 40, n);
    reset = 1'b1;
    tick();
    check("t6_rst_duty", 32'(duty), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("t6_rst_out", 32'(out), 32'd0);
    reset = 1'b0;
`ifdef PWM_RAMP_DONE_EN
    done_ref = done_cnt;
`endif
    send(4'd2, 4'd0, 4'd0, w);
    wait_change("t6_d1", 1, 40, n);
    wait_change("t6_d2", 2, 40, n);
    check("t6_per", 32'(n), 32'(PERIOD));
    check("t6_busy", 32'(busy), 32'd0);
    tick();
    tick();
`ifdef PWM_RAMP_DONE_EN
    check("t6_done", 32'(done_cnt - done_ref), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
